// File: rtl/mvm_datapath_bp.sv
// LANES-wide signed dot product with an accumulation memory, reduce add and credit-throttled output FIFO.
// Optional saturating arithmetic and sticky o_sat port when DATAPATH_SAT_EN is defined.
module mvm_datapath_bp #(
  parameter int LANES      = 64,
  parameter int IPREC      = 8,
  parameter int OPREC      = 32,
  parameter int MEM_DEPTH  = 512,
  parameter int ADDRW      = $clog2(MEM_DEPTH),
  parameter int FIFO_DEPTH = 8,
  parameter int DATAW      = LANES * IPREC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATAW-1:0]        i_dataa,
  input  logic [DATAW-1:0]        i_datab,
  input  logic signed [OPREC-1:0] i_datac,
  input  logic [ADDRW-1:0]        i_accum_addr,
  input  logic                    i_accum,
  input  logic                    i_last,
  input  logic                    i_reduce,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OPREC-1:0] o_result,
  output logic                    o_busy
`ifdef DATAPATH_SAT_EN
  ,
  output logic                    o_sat
`endif
);

  localparam int L     = 1 + $clog2(LANES);
  localparam int T     = L - 1;
  localparam int NODES = 2 * LANES - 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_next;
  logic [ADDRW-1:0] clr_addr;
  logic [CW-1:0]    pending;
  logic             accept, push, pop;

  logic signed [OPREC-1:0] prod [LANES];
  logic signed [OPREC-1:0] tree [NODES];
  logic signed [OPREC-1:0] mem  [MEM_DEPTH];

  logic                    sb_valid  [L];
  logic                    sb_last   [L];
  logic                    sb_accum  [L];
  logic                    sb_reduce [L];
  logic [ADDRW-1:0]        sb_addr   [L];
  logic signed [OPREC-1:0] sb_datac  [L];

  logic                    acc_valid, acc_last, acc_reduce;
  logic signed [OPREC-1:0] acc_sum, acc_datac;
  logic signed [OPREC-1:0] dpe, mem_rd, acc_add, sum_c, red_add, res_c;
  logic                    red_valid;
  logic signed [OPREC-1:0] red_res;

  logic signed [OPREC-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && clr_addr == ADDRW'(MEM_DEPTH - 1)) state_next = RUN;
  end

  // Credits cover both queued results and last beats still in the pipeline.
  always_comb begin
    o_busy  = (state == INIT);
    o_ready = (state == RUN) && (pending < CW'(FIFO_DEPTH));
  end

  assign accept = i_valid && o_ready;
  assign pop    = o_valid && i_ready;
  assign push   = red_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      case ({accept && i_last, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = OPREC'(signed'(i_dataa[k*IPREC +: IPREC])) *
                OPREC'(signed'(i_datab[k*IPREC +: IPREC]));
    end
  end

  // Heap-ordered tree: leaves at LANES-1.., root at 0, one register level per stage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) tree[LANES-1+k] <= prod[k];
    for (int i = 0; i < LANES - 1; i++) tree[i] <= tree[2*i+1] + tree[2*i+2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < L; s++) sb_valid[s] <= 1'b0;
    end else begin
      sb_valid[0] <= accept;
      for (int s = 1; s < L; s++) sb_valid[s] <= sb_valid[s-1];
    end
  end

  always_ff @(posedge clk) begin
    sb_last[0]   <= i_last;
    sb_accum[0]  <= i_accum;
    sb_reduce[0] <= i_reduce;
    sb_addr[0]   <= i_accum_addr;
    sb_datac[0]  <= i_datac;
    for (int s = 1; s < L; s++) begin
      sb_last[s]   <= sb_last[s-1];
      sb_accum[s]  <= sb_accum[s-1];
      sb_reduce[s] <= sb_reduce[s-1];
      sb_addr[s]   <= sb_addr[s-1];
      sb_datac[s]  <= sb_datac[s-1];
    end
  end

  assign dpe    = tree[0];
  assign mem_rd = mem[sb_addr[T]];

`ifdef DATAPATH_SAT_EN
  logic acc_clamp, red_clamp;

  function automatic logic [OPREC:0] sat_add(input logic signed [OPREC-1:0] a,
                                             input logic signed [OPREC-1:0] b);
    logic [OPREC:0] full;
    full = {a[OPREC-1], a} + {b[OPREC-1], b};
    if (full[OPREC] != full[OPREC-1])
      return full[OPREC] ? {2'b11, {(OPREC-1){1'b0}}} : {2'b10, {(OPREC-1){1'b1}}};
    return {1'b0, full[OPREC-1:0]};
  endfunction

  assign {acc_clamp, acc_add} = sat_add(mem_rd, dpe);
  assign {red_clamp, red_add} = sat_add(acc_sum, acc_datac);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sat <= 1'b0;
    end else if ((sb_valid[T] && sb_accum[T] && acc_clamp) ||
                 (acc_valid && acc_last && acc_reduce && red_clamp)) begin
      o_sat <= 1'b1;
    end
  end
`else
  assign acc_add = mem_rd + dpe;
  assign red_add = acc_sum + acc_datac;
`endif

  assign sum_c = sb_accum[T] ? acc_add : dpe;
  assign res_c = acc_reduce ? red_add : acc_sum;

  // Read and write share one stage, so back-to-back beats see the updated entry without forwarding.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[clr_addr] <= '0;
    else if (sb_valid[T]) mem[sb_addr[T]] <= sb_last[T] ? '0 : sum_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid <= 1'b0;
      red_valid <= 1'b0;
    end else begin
      acc_valid <= sb_valid[T];
      red_valid <= acc_valid && acc_last;
    end
  end

  always_ff @(posedge clk) begin
    acc_sum    <= sum_c;
    acc_last   <= sb_last[T];
    acc_reduce <= sb_reduce[T];
    acc_datac  <= sb_datac[T];
    red_res    <= res_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= red_res;
  end

  assign o_valid  = (count != '0);
  assign o_result = o_valid ? fifo_mem[rd_ptr] : '0;

endmodule
